snes_pad_responder: RTL
=======================

SNES_PAD_RESPONDER -- requirements
Module: snes_pad_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on snes_latch and snes_clock, legal range 2..4.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16'd4096: clock cycles without a pin edge before the frame is abandoned (used only with SNES_PAD_TIMEOUT_EN).
REQ-003 SHALL have port clock, input, 1 bit: the single clock for the block (cpu_clock domain, at least 8x the host bit rate).
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port buttons, input, 16 bits: active-low pad state (0 = pressed); bit i is the i-th serial bit (0=B,1=Y,2=Select,3=Start,4=Up,5=Down,6=Left,7=Right,8=A,9=X,10=L,11=R,12-15 ID).
REQ-006 SHALL have port snes_latch, input, 1 bit: asynchronous latch pin from the host, active-high.
REQ-007 SHALL have port snes_clock, input, 1 bit: asynchronous clock pin from the host, idle high.
REQ-008 SHALL have port snes_data, output, 1 bit: serial data to the host, active-low.
REQ-009 SHALL have port bit_count, output, 5 bits: number of bits shifted in the current frame, 0..16.
REQ-010 SHALL have port busy, output, 1 bit: high in states LATCH and SHIFT.
REQ-011 SHALL have port frame_done, output, 1 bit: one-cycle pulse when the 16th shift completes.

Function
REQ-012 SHALL pass snes_latch and snes_clock through SYNC_STAGES flops before any use; edges are detected on the synchronized copies only.
REQ-013 SHALL implement states IDLE, LATCH, SHIFT and DONE.
REQ-014 While in LATCH, the block SHALL reload the 16-bit shift register from buttons every cycle; snes_data = shift[0]; bit_count = 0.
REQ-015 On a synchronized latch rise from any state, the block SHALL enter LATCH.
REQ-016 On a synchronized latch fall, the block SHALL go LATCH -> SHIFT; the shift register holds its last-loaded value.
REQ-017 In SHIFT, on each synchronized snes_clock rising edge, the register SHALL shift right with a 0 shifted in and bit_count SHALL increment.
REQ-018 When bit_count reaches 16, the block SHALL assert frame_done for one cycle and enter DONE.
REQ-019 In DONE and IDLE, snes_data SHALL be 0 (low) and clock edges SHALL be ignored; bit_count SHALL saturate at 16 in DONE and be 0 in IDLE.
REQ-020 snes_data SHALL be registered; latency from a pin edge to a snes_data change is SYNC_STAGES+1 clock cycles.
REQ-021 If latch is high and a clock edge occurs in the same cycle, latch SHALL take priority: reload, no shift.
REQ-022 A snes_clock falling edge SHALL have no effect in any state.
REQ-023 Clock edges in LATCH SHALL be ignored.

Reset
REQ-024 On rst low, the block SHALL immediately (asynchronously) apply: state IDLE, shift register 16'hFFFF, sync flops latch=0 and clock=1, snes_data=0, bit_count=0, busy=0, frame_done=0, timeout counter 0.
REQ-025 Reset asserted mid-frame SHALL abandon the frame; after release, shifting SHALL NOT occur until a new latch rise is seen.

Configuration
REQ-026 With SNES_PAD_TIMEOUT_EN defined, a 16-bit counter SHALL clear on any synchronized pin edge and increment while in SHIFT; at TIMEOUT_CYCLES the block SHALL go to IDLE with no frame_done.
REQ-027 Without SNES_PAD_TIMEOUT_EN, no counter SHALL exist and SHIFT SHALL persist until 16 shifts or a latch rise.

Structure
REQ-028 Package snes_pad_pkg SHALL hold the state enum, the button index constants (B..R) and the frame length constant 16.
REQ-029 Sub-module snes_pad_sync SHALL implement the parameterized synchronizer plus rise/fall detect, instantiated once per pin.

Verification
REQ-030 buttons=16'hFEFE, latch pulse, 16 clocks -> snes_data sequence 0,1,1,1,1,1,1,1,0,1,1,1,1,1,1,1; frame_done once; bit_count=16.
REQ-031 Frame complete, then 4 extra clocks -> snes_data=0 throughout; bit_count stays 16; no further frame_done.
REQ-032 Latch re-raised after 5 shifts with buttons=16'h0F0F -> bit_count=0, snes_data=1 (bit0), next frame restarts from bit 0.
REQ-033 Latch high with a clock rise in the same cycle -> no shift; bit_count stays 0.
REQ-034 rst low after 7 shifts, then clocks without a latch -> state IDLE, snes_data=0, bit_count=0 throughout.
REQ-035 With SNES_PAD_TIMEOUT_EN and TIMEOUT_CYCLES=64: 3 shifts, then 64 idle cycles -> IDLE, busy=0, no frame_done.

Source files
------------

// File: rtl/snes_pad_pkg.sv
// Shared definitions for the SNES controller-side responder: FSM states,
// serial bit positions of each button and the frame length.
package snes_pad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LATCH = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } pad_state_e;

    // Serial position of each button within the 16-bit frame.
    localparam int unsigned BTN_B      = 0;
    localparam int unsigned BTN_Y      = 1;
    localparam int unsigned BTN_SELECT = 2;
    localparam int unsigned BTN_START  = 3;
    localparam int unsigned BTN_UP     = 4;
    localparam int unsigned BTN_DOWN   = 5;
    localparam int unsigned BTN_LEFT   = 6;
    localparam int unsigned BTN_RIGHT  = 7;
    localparam int unsigned BTN_A      = 8;
    localparam int unsigned BTN_X      = 9;
    localparam int unsigned BTN_L      = 10;
    localparam int unsigned BTN_R      = 11;

    // Bits per frame, and the count value at which the last shift happens.
    localparam logic [4:0] FRAME_LEN = 5'd16;
    localparam logic [4:0] LAST_BIT  = FRAME_LEN - 5'd1;

endpackage

// File: rtl/snes_pad_sync.sv
// Multi-flop synchronizer for one asynchronous host pin, with rise/fall
// detection on the synchronized copy. RESET_VAL is the pin's idle level so
// that reset release never produces a false edge.
module snes_pad_sync #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_i,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Shift the pin through the synchronizer chain and keep one delayed copy
    // of the synchronized level for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the
            // pre-edge value, so the chain really is STAGES flops deep.
            sync_q <= {sync_q[STAGES-2:0], pin_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise_o = sync_q[STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/snes_pad_responder.sv
// Controller-side SNES pad responder: latches the active-low button word on
// the host latch pulse and shifts it out LSB first on host clock rises.
// Optional feature: define SNES_PAD_TIMEOUT_EN to abandon a stalled frame
// after TIMEOUT_CYCLES clocks without any synchronized pin edge.
module snes_pad_responder
    import snes_pad_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096
) (
    input  logic        clock,
    input  logic        rst,
    input  logic [15:0] buttons,
    input  logic        snes_latch,
    input  logic        snes_clock,
    output logic        snes_data,
    output logic [4:0]  bit_count,
    output logic        busy,
    output logic        frame_done
);

    logic latch_rise, latch_fall;
    logic clk_rise, clk_fall;
    logic timeout_hit;

    pad_state_e  state_q;
    logic [15:0] shift_q, shift_d;
    logic [4:0]  count_q;
    logic        data_q, busy_q, done_q;

    snes_pad_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_latch_sync (
        .clk    (clock),
        .rst_n  (rst),
        .pin_i  (snes_latch),
        .rise_o (latch_rise),
        .fall_o (latch_fall)
    );

    // Host clock idles high, so its synchronizer resets to 1.
    snes_pad_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_clock_sync (
        .clk    (clock),
        .rst_n  (rst),
        .pin_i  (snes_clock),
        .rise_o (clk_rise),
        .fall_o (clk_fall)
    );

    assign shift_d = {1'b0, shift_q[15:1]};

`ifdef SNES_PAD_TIMEOUT_EN
    logic [15:0] tmo_q, tmo_d;
    logic        pin_edge;

    assign pin_edge = latch_rise | latch_fall | clk_rise | clk_fall;

    // Stall counter: restarts on any pin activity, runs only while shifting.
    always_comb begin
        tmo_d = tmo_q;
        if (pin_edge) begin
            tmo_d = 16'd0;
        end else if (state_q == ST_SHIFT) begin
            tmo_d = tmo_q + 16'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            tmo_q <= 16'd0;
        end else begin
            tmo_q <= tmo_d;
        end
    end

    assign timeout_hit = (state_q == ST_SHIFT) && (tmo_q == TIMEOUT_CYCLES);
`else
    logic [16:0] unused_cfg;

    assign unused_cfg  = {clk_fall, TIMEOUT_CYCLES};
    assign timeout_hit = 1'b0;
`endif

    // Frame FSM with registered outputs; a latch rise restarts from any state.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            shift_q <= 16'hFFFF;
            count_q <= 5'd0;
            data_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (latch_rise) begin
                state_q <= ST_LATCH;
                shift_q <= buttons;
                count_q <= 5'd0;
                data_q  <= buttons[0];
                busy_q  <= 1'b1;
            end else begin
                case (state_q)
                    ST_LATCH: begin
                        if (latch_fall) begin
                            state_q <= ST_SHIFT;
                        end else begin
                            shift_q <= buttons;
                            data_q  <= buttons[0];
                        end
                    end
                    ST_SHIFT: begin
                        if (clk_rise) begin
                            shift_q <= shift_d;
                            count_q <= count_q + 5'd1;
                            if (count_q == LAST_BIT) begin
                                state_q <= ST_DONE;
                                data_q  <= 1'b0;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                data_q <= shift_d[0];
                            end
                        end else if (timeout_hit) begin
                            state_q <= ST_IDLE;
                            count_q <= 5'd0;
                            data_q  <= 1'b0;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: begin
                        // IDLE and DONE ignore host clock activity.
                    end
                endcase
            end
        end
    end

    assign snes_data  = data_q;
    assign bit_count  = count_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule
